dkong_vram_arb: RTL and testbench

Sequencer/arbiter for the single-port 1024x8 tile VRAM. It shares the RAM between three requesters: video tile fetch, Z80 CPU and the hiscore save/restore port. It drives the RAM address, data and strobes, and returns read data to each requester. It sits between the CPU bus decode, the H/V timing generator and the VRAM macro, and presents the fetched tile code to the character ROM stage.

---
 rtl/dkong_vram_pkg.sv | 30 +++
 rtl/dkong_vram_cpu_if.sv | 42 ++++
 rtl/dkong_vram_arb.sv | 158 +++++++++++++++
 tb/tb_dkong_vram_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dkong_vram_pkg.sv
// rtl/dkong_vram_pkg.sv - shared types and constants for the tile VRAM arbiter
package dkong_vram_pkg;

  localparam int RAM_DEPTH = 1024;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam int RAM_DW    = 8;

  localparam logic [3:0] DEF_VID_SLOT   = 4'd7;
  localparam int         DEF_STARVE_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_HS  = 2'd2
  } owner_t;

  // Tile row from the flipped vertical count, column from H[8:4], mirrored on flip.
  function automatic logic [RAM_AW-1:0] vid_addr(input logic [4:0] row,
                                                 input logic [4:0] col,
                                                 input logic       flip);
    return {row, col ^ {5{flip}}};
  endfunction

endpackage

// File: rtl/dkong_vram_cpu_if.sv
// rtl/dkong_vram_cpu_if.sv - Z80 strobe decode, completion flag, WAITn and read-data hold
module dkong_vram_cpu_if
  import dkong_vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              capture,
  input  logic              capture_rd,
  input  logic [RAM_DW-1:0] ram_do,
  output logic              pending,
  output logic              is_write,
  output logic [RAM_DW-1:0] cpu_db,
  output logic              wait_n
);

  logic done;
  logic strobe;

  assign strobe   = ~rd_n | ~wr_n;
  // Both strobes low is decoded as a write.
  assign is_write = ~wr_n;
  assign pending  = strobe & ~done;
  assign wait_n   = ~pending | ~rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      cpu_db <= '0;
    end else if (clk_en) begin
      if (!strobe)
        done <= 1'b0;
      else if (capture)
        done <= 1'b1;
      if (capture_rd)
        cpu_db <= ram_do;
    end
  end

endmodule

// File: rtl/dkong_vram_arb.sv
// rtl/dkong_vram_arb.sv - VRAM sequencer for video/CPU/hiscore; DKONG_VRAM_ARB_HS_EN builds the hiscore port
module dkong_vram_arb
  import dkong_vram_pkg::*;
#(
  parameter logic [3:0] VID_SLOT   = DEF_VID_SLOT,
  parameter int         STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              CLK_24M,
  input  logic              I_RSTn,
  input  logic              CLK_EN,
  input  logic [9:0]        I_H_CNT,
  input  logic [7:0]        I_VF_CNT,
  input  logic              I_CMPBLK,
  input  logic              I_FLIP,
  input  logic [RAM_AW-1:0] I_CPU_AB,
  input  logic [RAM_DW-1:0] I_CPU_DB,
  input  logic              I_CPU_RDn,
  input  logic              I_CPU_WRn,
  output logic [RAM_DW-1:0] O_CPU_DB,
  output logic              O_CPU_WAITn,
  input  logic [RAM_AW-1:0] hs_address,
  input  logic [RAM_DW-1:0] hs_data_in,
  input  logic              hs_we,
  input  logic              hs_req,
  output logic              hs_ack,
  output logic [RAM_DW-1:0] hs_data_out,
  output logic [RAM_AW-1:0] O_RAM_AB,
  output logic [RAM_DW-1:0] O_RAM_DB,
  output logic              O_RAM_CE,
  output logic              O_RAM_WE,
  input  logic [RAM_DW-1:0] I_RAM_DO,
  output logic [RAM_DW-1:0] O_VID_CODE,
  output logic              O_VID_STB
);

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  logic   acc_we;
  logic   grant_vid, grant_cpu, grant_hs, grant_any;
  logic   cpu_pending, cpu_write;
  logic   hs_pending, hs_force;
  logic   vid_trig, capture;
  logic   unused_cnt_bits;

  assign unused_cnt_bits = ^{I_H_CNT[9], I_VF_CNT[2:0]};

  assign vid_trig  = I_CMPBLK && (I_H_CNT[3:0] == VID_SLOT);
  assign capture   = (state == ST_CAPTURE);
  assign grant_any = grant_vid | grant_cpu | grant_hs;

  dkong_vram_cpu_if u_cpu_if (
    .clk        (CLK_24M),
    .rst_n      (I_RSTn),
    .clk_en     (CLK_EN),
    .rd_n       (I_CPU_RDn),
    .wr_n       (I_CPU_WRn),
    .capture    (capture && owner == OWN_CPU),
    .capture_rd (capture && owner == OWN_CPU && !acc_we),
    .ram_do     (I_RAM_DO),
    .pending    (cpu_pending),
    .is_write   (cpu_write),
    .cpu_db     (O_CPU_DB),
    .wait_n     (O_CPU_WAITn)
  );

`ifdef DKONG_VRAM_ARB_HS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  assign hs_pending = hs_req;
  assign hs_force   = hs_req && (starve_cnt >= SW'(STARVE_MAX));

  // Counts CPU grants that overtook a waiting hiscore request.
  always_ff @(posedge CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      starve_cnt  <= '0;
      hs_ack      <= 1'b0;
      hs_data_out <= '0;
    end else if (CLK_EN) begin
      if (grant_hs || !hs_req)
        starve_cnt <= '0;
      else if (grant_cpu && starve_cnt < SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      hs_ack <= capture && owner == OWN_HS;
      if (capture && owner == OWN_HS && !acc_we)
        hs_data_out <= I_RAM_DO;
    end
  end
`else
  assign hs_pending  = 1'b0;
  assign hs_force    = 1'b0;
  assign hs_ack      = 1'b0;
  assign hs_data_out = '0;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    grant_hs  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vid_trig)
          grant_vid = 1'b1;
        else if (!I_CMPBLK) begin
          if (cpu_pending && !hs_force)
            grant_cpu = 1'b1;
          else if (hs_pending)
            grant_hs = 1'b1;
        end
        if (grant_vid) begin
          state_nxt = ST_ISSUE;
          owner_nxt = OWN_VID;
        end else if (grant_cpu) begin
          state_nxt = ST_ISSUE;
          owner_nxt = OWN_CPU;
        end else if (grant_hs) begin
          state_nxt = ST_ISSUE;
          owner_nxt = OWN_HS;
        end
      end
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // RAM controls are loaded on the grant edge so they are stable throughout ISSUE.
  always_ff @(posedge CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state      <= ST_IDLE;
      owner      <= OWN_VID;
      acc_we     <= 1'b0;
      O_RAM_AB   <= '0;
      O_RAM_DB   <= '0;
      O_RAM_CE   <= 1'b0;
      O_RAM_WE   <= 1'b0;
      O_VID_CODE <= '0;
      O_VID_STB  <= 1'b0;
    end else if (CLK_EN) begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      O_RAM_CE <= grant_any;
      O_RAM_WE <= (grant_cpu && cpu_write) || (grant_hs && hs_we);
      if (grant_any) begin
        acc_we   <= (grant_cpu && cpu_write) || (grant_hs && hs_we);
        O_RAM_AB <= grant_vid ? vid_addr(I_VF_CNT[7:3], I_H_CNT[8:4], I_FLIP)
                  : grant_hs  ? hs_address : I_CPU_AB;
        O_RAM_DB <= grant_hs ? hs_data_in : I_CPU_DB;
      end
      O_VID_STB <= capture && owner == OWN_VID;
      if (capture && owner == OWN_VID)
        O_VID_CODE <= I_RAM_DO;
    end
  end

endmodule

// File: tb/tb_dkong_vram_arb.sv
// tb/tb_dkong_vram_arb.sv - directed self-checking bench for dkong_vram_arb with a 1024x8 sync RAM model
module tb_dkong_vram_arb;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, cmpblk, flip;
  logic [9:0] h_cnt, cpu_ab, hs_address, ram_ab;
  logic [7:0] vf_cnt, cpu_db_in, cpu_db, hs_data_in, hs_data_out, ram_db, ram_do, vid_code;
  logic       rd_n, wr_n, wait_n, hs_we, hs_req, hs_ack, ram_ce, ram_we, vid_stb;

  logic [7:0] mem [1024];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clk_en && ram_ce) begin
      ram_do <= mem[ram_ab];
      if (ram_we) mem[ram_ab] = ram_db;
    end
  end

  dkong_vram_arb dut (
    .CLK_24M(clk), .I_RSTn(rst_n), .CLK_EN(clk_en),
    .I_H_CNT(h_cnt), .I_VF_CNT(vf_cnt), .I_CMPBLK(cmpblk), .I_FLIP(flip),
    .I_CPU_AB(cpu_ab), .I_CPU_DB(cpu_db_in), .I_CPU_RDn(rd_n), .I_CPU_WRn(wr_n),
    .O_CPU_DB(cpu_db), .O_CPU_WAITn(wait_n),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_we(hs_we), .hs_req(hs_req),
    .hs_ack(hs_ack), .hs_data_out(hs_data_out),
    .O_RAM_AB(ram_ab), .O_RAM_DB(ram_db), .O_RAM_CE(ram_ce), .O_RAM_WE(ram_we),
    .I_RAM_DO(ram_do), .O_VID_CODE(vid_code), .O_VID_STB(vid_stb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants, hs_issues, acks, phase, grants_at_hs;
    logic [7:0] hs_seen;
    grants = 0; hs_issues = 0; acks = 0; phase = 0; grants_at_hs = -1; hs_seen = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst_n = 1'b0; clk_en = 1'b1; cmpblk = 1'b0; flip = 1'b0;
    h_cnt = '0; vf_cnt = '0; cpu_ab = '0; cpu_db_in = '0; rd_n = 1'b1; wr_n = 1'b1;
    hs_address = '0; hs_data_in = '0; hs_we = 1'b0; hs_req = 1'b0;
    #3;
    chk("rst_ab", ram_ab, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_vid_code", vid_code, 0);
    chk("rst_vid_stb", vid_stb, 0);
    chk("rst_waitn", wait_n, 1);
    chk("rst_hs_ack", hs_ack, 0);
    chk("rst_cpu_db", cpu_db, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Video fetch, no flip: row 5, column 3
    cmpblk = 1'b1; vf_cnt = 8'h28; h_cnt = 10'h037; clk_en = 1'b0;
    tick();
    chk("clk_en_gate_ce", ram_ce, 0);
    clk_en = 1'b1;
    tick();
    chk("vid_ab", ram_ab, 10'h0A3);
    chk("vid_ce", ram_ce, 1);
    chk("vid_we", ram_we, 0);
    h_cnt = 10'h038;
    tick();
    chk("vid_ce_drop", ram_ce, 0);
    chk("vid_stb_early", vid_stb, 0);
    tick();
    chk("vid_stb", vid_stb, 1);
    chk("vid_code", vid_code, 8'h06);
    tick();
    chk("vid_stb_pulse", vid_stb, 0);

    // Video fetch, flipped
    flip = 1'b1; h_cnt = 10'h037;
    tick();
    chk("vid_flip_ab", ram_ab, 10'h0BC);
    h_cnt = 10'h038;
    tick(); tick();
    chk("vid_flip_stb", vid_stb, 1);
    chk("vid_flip_code", vid_code, 8'h19);
    tick();
    cmpblk = 1'b0; flip = 1'b0; h_cnt = '0;

    // CPU write in blanking, then read back
    cpu_ab = 10'h155; cpu_db_in = 8'h5A; wr_n = 1'b0;
    #1 chk("wr_waitn_req", wait_n, 0);
    tick();
    chk("wr_issue_we", ram_we, 1);
    chk("wr_issue_ab", ram_ab, 10'h155);
    chk("wr_issue_db", ram_db, 8'h5A);
    chk("wr_issue_waitn", wait_n, 0);
    tick();
    chk("wr_we_one_cycle", ram_we, 0);
    chk("wr_capture_waitn", wait_n, 0);
    tick();
    chk("wr_done_waitn", wait_n, 1);
    chk("wr_mem", mem[10'h155], 8'h5A);
    wr_n = 1'b1;
    tick();
    rd_n = 1'b0;
    tick(); tick(); tick();
    chk("rd_back_db", cpu_db, 8'h5A);
    chk("rd_back_waitn", wait_n, 1);
    rd_n = 1'b1;
    tick();

    // CPU read requested during active display
    cmpblk = 1'b1; cpu_ab = 10'h3F0; rd_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("disp_no_ce", ram_ce, 0);
      chk("disp_waitn", wait_n, 0);
    end
    cmpblk = 1'b0;
    tick();
    chk("disp_grant_ab", ram_ab, 10'h3F0);
    chk("disp_grant_ce", ram_ce, 1);
    tick(); tick();
    chk("disp_db", cpu_db, 8'h55);
    chk("disp_waitn_done", wait_n, 1);
    rd_n = 1'b1;
    tick();

    // Starvation: hiscore held while the CPU re-requests back to back
    cpu_ab = 10'h200; cpu_db_in = 8'h77; hs_address = 10'h155; hs_we = 1'b0;
    hs_req = 1'b1; wr_n = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ram_ce && ram_we) begin
        grants++; wr_n = 1'b1; phase = 2;
      end else if (ram_ce) begin
        hs_issues++; grants_at_hs = grants;
      end else if (phase > 0) begin
        phase--;
        if (phase == 0) wr_n = 1'b0;
      end
      if (hs_ack) begin
        acks++; hs_req = 1'b0; hs_seen = hs_data_out;
      end
    end
    wr_n = 1'b1; hs_req = 1'b0;
    repeat (4) tick();
`ifdef DKONG_VRAM_ARB_HS_EN
    chk("starve_cpu_grants", grants_at_hs, 8);
    chk("starve_hs_issues", hs_issues, 1);
    chk("starve_hs_acks", acks, 1);
    chk("starve_hs_data", hs_seen, 8'h5A);
`else
    chk("nohs_issues", hs_issues, 0);
    chk("nohs_acks", acks, 0);
    chk("nohs_data", hs_data_out, 0);
`endif

    // Simultaneous CPU and hiscore requests with the counter clear
    cpu_ab = 10'h012; rd_n = 1'b0; hs_req = 1'b1;
    tick();
    chk("simul_cpu_first_ab", ram_ab, 10'h012);
    chk("simul_cpu_first_ce", ram_ce, 1);
    tick(); tick();
    chk("simul_cpu_db", cpu_db, 8'hB7);
    rd_n = 1'b1;
    tick();
`ifdef DKONG_VRAM_ARB_HS_EN
    chk("simul_hs_ab", ram_ab, 10'h155);
    chk("simul_hs_ce", ram_ce, 1);
    tick(); tick();
    chk("simul_hs_ack", hs_ack, 1);
`else
    chk("simul_nohs_ce", ram_ce, 0);
    tick(); tick();
    chk("simul_nohs_ack", hs_ack, 0);
`endif
    hs_req = 1'b0;
    tick(); tick();

    // Reset asserted during a CPU write ISSUE
    cpu_ab = 10'h2AA; cpu_db_in = 8'hC3; wr_n = 1'b0;
    tick();
    chk("rstw_issue_we", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_async", ram_we, 0);
    chk("rstw_ce_async", ram_ce, 0);
    chk("rstw_waitn", wait_n, 1);
    tick();
    chk("rstw_mem_kept", mem[10'h2AA], 8'h0F);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wait_n) break;
    end
    chk("rstw_resume_waitn", wait_n, 1);
    chk("rstw_resume_mem", mem[10'h2AA], 8'hC3);
    wr_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
